// File: rtl/cocofpga_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: access FSM state encoding, requester port indices and the
// external SRAM address width.
package cocofpga_pkg;

    // External SRAM address width; requester addresses are zero-extended to it.
    localparam int SRAM_ADDR_W = 18;

    // Requester port indices (AVR/SPI is A, Coco bus is B).
    localparam int PORT_A = 0;
    localparam int PORT_B = 1;

    // Access FSM states. Encoding is fixed so it stays stable in debug dumps.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of requester handshakes, status and SRAM pin signals for sram_arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requesters fire one-cycle pulses and watch done/overrun.
//
// Modports:
//   slave  - the arbiter: consumes requests and sram_dq_in, drives done/rdata,
//            overrun, busy and all SRAM strobes/address/data-out.
//   master - the environment (SPI decoder, Coco decoder, SRAM pins).
interface sram_arbiter_if #(
    parameter int ADDR_W = 16
);
    import cocofpga_pkg::*;

    // Port A (AVR/SPI)
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_wdata;
    logic              a_done;
    logic [7:0]        a_rdata;

    // Port B (Coco bus)
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_wdata;
    logic              b_done;
    logic [7:0]        b_rdata;

    // Status
    logic [1:0]        overrun;   // sticky {B, A}
    logic              busy;

    // SRAM pins
    sram_addr_t        sram_addr;
    logic [7:0]        sram_dq_out;
    logic              sram_dq_oe;
    logic [7:0]        sram_dq_in;
    logic              sram_we_n;
    logic              sram_oe_n;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  sram_dq_in,
        output a_done, a_rdata, b_done, b_rdata,
        output overrun, busy,
        output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output sram_dq_in,
        input  a_done, a_rdata, b_done, b_rdata,
        input  overrun, busy,
        input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

endinterface

// File: rtl/sram_req_latch.sv
// Per-port request holding register: captures we/addr/wdata on a req pulse.
// Latency: pending is visible the cycle after the req pulse.
// Backpressure: none; a pulse while already pending is dropped and flagged in a sticky overrun.
//
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/we_i/addr_i/wdata_i
// request pulse and payload; clr_i grant strobe from the arbiter; pend_o,
// we_o, addr_o, wdata_o held request; overrun_o sticky drop flag.
module sram_req_latch
    import cocofpga_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    input  logic              clr_i,
    output logic              pend_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wdata_o,
    output logic              overrun_o
);

    logic              pend_q, pend_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              ovr_q, ovr_d;
    logic              load;

    always_comb begin
        // A pulse on the grant edge is accepted: the arbiter copies the old
        // contents on that same edge, so the slot is free to take the new one.
        load    = req_i && (!pend_q || clr_i);
        pend_d  = pend_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ovr_d   = ovr_q | (req_i && pend_q && !clr_i);

        if (load) begin
            pend_d  = 1'b1;
            we_d    = we_i;
            addr_d  = addr_i;
            wdata_d = wdata_i;
        end else if (clr_i) begin
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovr_q   <= ovr_d;
        end
    end

    assign pend_o    = pend_q;
    assign we_o      = we_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/sram_arbiter.sv
// Sole owner of the external 8-bit SRAM: serialises single-byte accesses from port A (SPI) and port B (Coco).
// Latency: on an idle bus done is registered ACCESS_CYCLES+3 edges after the edge that captures req.
// Backpressure: one request held per port; extra pulses while pending are dropped and flagged in overrun.
//
// Ports: clock_50, reset_n (async active-low); bus (sram_arbiter_if.slave) carrying
// both requester handshakes, overrun/busy status and the SRAM pins.
// ACCESS_CYCLES and MAX_CONSEC are meaningful in 1..15 (4-bit counters).
module sram_arbiter
    import cocofpga_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int ACCESS_CYCLES = 6,
    parameter int MAX_CONSEC    = 4
) (
    input  logic          clock_50,
    input  logic          reset_n,
    sram_arbiter_if.slave bus
);

    localparam logic OWN_A = 1'(PORT_A);
    localparam logic OWN_B = 1'(PORT_B);

    // Held requests from the two latches
    logic              a_pend, a_we, a_ovr, clr_a;
    logic [ADDR_W-1:0] a_addr;
    logic [7:0]        a_wdata;
    logic              b_pend, b_we, b_ovr, clr_b;
    logic [ADDR_W-1:0] b_addr;
    logic [7:0]        b_wdata;

    // FSM and bus registers
    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] consec_q, consec_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    sram_addr_t addr_q, addr_d;
    logic [7:0] dq_out_q, dq_out_d;
    logic       dq_oe_q, dq_oe_d;
    logic       we_n_q, we_n_d;
    logic       oe_n_q, oe_n_d;
    logic       busy_q, busy_d;
    logic       a_done_q, a_done_d;
    logic       b_done_q, b_done_d;
    logic [7:0] a_rdata_q, a_rdata_d;
    logic [7:0] b_rdata_q, b_rdata_d;
    logic       grant_b;

    sram_req_latch #(.ADDR_W(ADDR_W)) u_latch_a (
        .clk_i     (clock_50),
        .rst_ni    (reset_n),
        .req_i     (bus.a_req),
        .we_i      (bus.a_we),
        .addr_i    (bus.a_addr),
        .wdata_i   (bus.a_wdata),
        .clr_i     (clr_a),
        .pend_o    (a_pend),
        .we_o      (a_we),
        .addr_o    (a_addr),
        .wdata_o   (a_wdata),
        .overrun_o (a_ovr)
    );

    sram_req_latch #(.ADDR_W(ADDR_W)) u_latch_b (
        .clk_i     (clock_50),
        .rst_ni    (reset_n),
        .req_i     (bus.b_req),
        .we_i      (bus.b_we),
        .addr_i    (bus.b_addr),
        .wdata_i   (bus.b_wdata),
        .clr_i     (clr_b),
        .pend_o    (b_pend),
        .we_o      (b_we),
        .addr_o    (b_addr),
        .wdata_o   (b_wdata),
        .overrun_o (b_ovr)
    );

    // A has priority, except that B is forced once A has taken MAX_CONSEC
    // grants in a row while B was waiting.
    assign grant_b = b_pend && (!a_pend || (consec_q == 4'(MAX_CONSEC)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        consec_d  = consec_q;
        owner_d   = owner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        clr_a     = 1'b0;
        clr_b     = 1'b0;

        // The starvation count only means something while B is waiting.
        if (!b_pend) begin
            consec_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (a_pend || b_pend) begin
                    state_d = ST_SETUP;
                    if (grant_b) begin
                        owner_d  = OWN_B;
                        wr_d     = b_we;
                        addr_d   = SRAM_ADDR_W'(b_addr);
                        dq_out_d = b_wdata;
                        clr_b    = 1'b1;
                        consec_d = '0;
                    end else begin
                        owner_d  = OWN_A;
                        wr_d     = a_we;
                        addr_d   = SRAM_ADDR_W'(a_addr);
                        dq_out_d = a_wdata;
                        clr_a    = 1'b1;
                        if (b_pend) begin
                            consec_d = consec_q + 4'd1;
                        end
                    end
                end
            end

            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = 4'(ACCESS_CYCLES - 1);
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    // Sample read data on the last strobe edge, while oe_n is still low.
                    if (!wr_q) begin
                        if (owner_q == OWN_B) begin
                            b_rdata_d = bus.sram_dq_in;
                        end else begin
                            a_rdata_d = bus.sram_dq_in;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_HOLD: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_B) begin
                    b_done_d = 1'b1;
                end else begin
                    a_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin controls are decoded from the next state so the registered strobes
    // line up exactly with the state they belong to; we_n and oe_n are keyed
    // on opposite values of wr_d, so they can never be low together.
    always_comb begin
        we_n_d  = !((state_d == ST_ACCESS) && wr_d);
        oe_n_d  = !((state_d == ST_ACCESS) && !wr_d);
        dq_oe_d = (state_d != ST_IDLE) && wr_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            consec_q  <= '0;
            owner_q   <= OWN_A;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            dq_out_q  <= '0;
            dq_oe_q   <= 1'b0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            consec_q  <= consec_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dq_oe_q   <= dq_oe_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            busy_q    <= busy_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign bus.a_done      = a_done_q;
    assign bus.a_rdata     = a_rdata_q;
    assign bus.b_done      = b_done_q;
    assign bus.b_rdata     = b_rdata_q;
    assign bus.overrun     = {b_ovr, a_ovr};
    assign bus.busy        = busy_q;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arbiter;
    import cocofpga_pkg::*;

    logic clock_50 = 1'b0;
    logic reset_n  = 1'b0;
    always #5 clock_50 = ~clock_50;

    sram_arbiter_if #(.ADDR_W(16)) bus ();

    sram_arbiter #(
        .ADDR_W        (16),
        .ACCESS_CYCLES (6),
        .MAX_CONSEC    (4)
    ) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    // SRAM model: written on rising edges while we_n is low, read data
    // presented half a cycle later while oe_n is low.
    logic [7:0] mem [0:65535];
    logic [7:0] sram_dq;
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        forever begin
            @(posedge clock_50);
            if (!bus.sram_we_n) mem[bus.sram_addr[15:0]] = bus.sram_dq_out;
        end
    end
    always @(negedge clock_50) sram_dq = bus.sram_oe_n ? 8'h00 : mem[bus.sram_addr[15:0]];
    assign bus.sram_dq_in = sram_dq;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scheduled request pulses: edge_no counts rising edges from watch() start.
    typedef struct {
        int         port;
        int         edge_no;
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
    } req_t;
    req_t sched[$];

    // Observations gathered by watch()
    int ev_port[$];
    int ev_cyc[$];
    int we_lo, oe_lo, dqoe_hi, busy_hi, glitch;
    int addr_seen;

    task automatic watch(input int n);
        ev_port.delete();
        ev_cyc.delete();
        we_lo = 0; oe_lo = 0; dqoe_hi = 0; busy_hi = 0; glitch = 0; addr_seen = -1;
        for (int i = 1; i <= n; i++) begin
            bus.a_req = 1'b0;
            bus.b_req = 1'b0;
            foreach (sched[k]) begin
                if (sched[k].edge_no == i) begin
                    if (sched[k].port == 0) begin
                        bus.a_req = 1'b1; bus.a_we = sched[k].we;
                        bus.a_addr = sched[k].addr; bus.a_wdata = sched[k].wdata;
                    end else begin
                        bus.b_req = 1'b1; bus.b_we = sched[k].we;
                        bus.b_addr = sched[k].addr; bus.b_wdata = sched[k].wdata;
                    end
                end
            end
            @(negedge clock_50);
            if (!bus.sram_we_n) we_lo++;
            if (!bus.sram_oe_n) oe_lo++;
            if (!bus.sram_we_n && !bus.sram_oe_n) glitch++;
            if (bus.sram_dq_oe) dqoe_hi++;
            if (bus.busy) busy_hi++;
            if (!bus.sram_we_n || !bus.sram_oe_n) addr_seen = int'(bus.sram_addr);
            if (bus.a_done) begin ev_port.push_back(0); ev_cyc.push_back(i); end
            if (bus.b_done) begin ev_port.push_back(1); ev_cyc.push_back(i); end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        sched.delete();
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;
    vec_t vt[7];

    int exp_p[6];
    int exp_c[6];

    initial begin
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;

        vt[0] = '{0, 1'b1, 16'h1234, 8'hA5, 8'h00};
        vt[1] = '{1, 1'b0, 16'h1234, 8'h00, 8'hA5};
        vt[2] = '{1, 1'b1, 16'hFFFF, 8'h3C, 8'h00};
        vt[3] = '{0, 1'b0, 16'hFFFF, 8'h00, 8'h3C};
        vt[4] = '{0, 1'b0, 16'h0000, 8'h00, 8'h00};
        vt[5] = '{1, 1'b1, 16'h0000, 8'hC3, 8'h00};
        vt[6] = '{1, 1'b0, 16'h0000, 8'h00, 8'hC3};

        // Reset state
        repeat (3) @(negedge clock_50);
        chk("rst_a_done",  int'(bus.a_done), 0);
        chk("rst_b_done",  int'(bus.b_done), 0);
        chk("rst_a_rdata", int'(bus.a_rdata), 0);
        chk("rst_b_rdata", int'(bus.b_rdata), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_busy",    int'(bus.busy), 0);
        chk("rst_addr",    int'(bus.sram_addr), 0);
        chk("rst_dq_out",  int'(bus.sram_dq_out), 0);
        chk("rst_dq_oe",   int'(bus.sram_dq_oe), 0);
        chk("rst_we_n",    int'(bus.sram_we_n), 1);
        chk("rst_oe_n",    int'(bus.sram_oe_n), 1);
        reset_n = 1'b1;
        @(negedge clock_50);

        // Single transactions on an idle bus
        for (int v = 0; v < 7; v++) begin
            sched.push_back('{vt[v].port, 1, vt[v].we, vt[v].addr, vt[v].wdata});
            watch(14);
            chk($sformatf("v%0d_ndone", v), ev_port.size(), 1);
            if (ev_port.size() >= 1) begin
                chk($sformatf("v%0d_port", v), ev_port[0], vt[v].port);
                chk($sformatf("v%0d_latency", v), ev_cyc[0] - 1, 9);
            end
            chk($sformatf("v%0d_we_lo", v), we_lo, vt[v].we ? 6 : 0);
            chk($sformatf("v%0d_oe_lo", v), oe_lo, vt[v].we ? 0 : 6);
            chk($sformatf("v%0d_dqoe", v), dqoe_hi, vt[v].we ? 8 : 0);
            chk($sformatf("v%0d_glitch", v), glitch, 0);
            chk($sformatf("v%0d_addr", v), addr_seen, int'({2'b00, vt[v].addr}));
            if (vt[v].we)
                chk($sformatf("v%0d_mem", v), int'(mem[vt[v].addr]), int'(vt[v].wdata));
            else if (vt[v].port == 0)
                chk($sformatf("v%0d_a_rdata", v), int'(bus.a_rdata), int'(vt[v].exp_rdata));
            else
                chk($sformatf("v%0d_b_rdata", v), int'(bus.b_rdata), int'(vt[v].exp_rdata));
        end

        // Simultaneous requests: A first, B right after A's HOLD
        sched.push_back('{0, 1, 1'b1, 16'h4000, 8'h5A});
        sched.push_back('{1, 1, 1'b1, 16'h4001, 8'h6B});
        watch(25);
        chk("sim_ndone", ev_port.size(), 2);
        if (ev_port.size() >= 2) begin
            chk("sim_first_port",  ev_port[0], 0);
            chk("sim_first_cyc",   ev_cyc[0], 10);
            chk("sim_second_port", ev_port[1], 1);
            chk("sim_second_cyc",  ev_cyc[1], 19);
        end
        chk("sim_mem_a", int'(mem[16'h4000]), 8'h5A);
        chk("sim_mem_b", int'(mem[16'h4001]), 8'h6B);
        chk("sim_glitch", glitch, 0);

        // Starvation guard: A re-requests on every grant edge while B waits
        sched.push_back('{1, 1,  1'b1, 16'h5100, 8'hBB});
        sched.push_back('{0, 1,  1'b1, 16'h5000, 8'h00});
        sched.push_back('{0, 2,  1'b1, 16'h5001, 8'h01});
        sched.push_back('{0, 11, 1'b1, 16'h5002, 8'h02});
        sched.push_back('{0, 20, 1'b1, 16'h5003, 8'h03});
        sched.push_back('{0, 29, 1'b1, 16'h5004, 8'h04});
        watch(65);
        exp_p = '{0, 0, 0, 0, 1, 0};
        exp_c = '{10, 19, 28, 37, 46, 55};
        chk("starve_ndone", ev_port.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ev_port.size()) begin
                chk($sformatf("starve_port%0d", i), ev_port[i], exp_p[i]);
                chk($sformatf("starve_cyc%0d", i), ev_cyc[i], exp_c[i]);
            end
        end
        chk("starve_mem_b", int'(mem[16'h5100]), 8'hBB);
        chk("starve_mem_a4", int'(mem[16'h5004]), 8'h04);
        chk("starve_no_overrun", int'(bus.overrun), 0);

        // Overrun: second A pulse while A waits behind B is dropped
        sched.push_back('{1, 1, 1'b1, 16'h6000, 8'h99});
        sched.push_back('{0, 2, 1'b1, 16'h2000, 8'h11});
        sched.push_back('{0, 5, 1'b1, 16'h2001, 8'h22});
        watch(25);
        chk("ovr_flag", int'(bus.overrun), 2'b01);
        chk("ovr_ndone", ev_port.size(), 2);
        if (ev_port.size() >= 2) begin
            chk("ovr_first_port", ev_port[0], 1);
            chk("ovr_second_port", ev_port[1], 0);
            chk("ovr_second_cyc", ev_cyc[1], 19);
        end
        chk("ovr_mem_orig", int'(mem[16'h2000]), 8'h11);
        chk("ovr_mem_dropped", int'(mem[16'h2001]), 8'h00);

        // Reset in the middle of a write access
        sched.push_back('{0, 1, 1'b1, 16'h3000, 8'h77});
        watch(5);
        chk("mid_we_n_low", int'(bus.sram_we_n), 0);
        chk("ovr_sticky", int'(bus.overrun), 2'b01);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we_n", int'(bus.sram_we_n), 1);
        chk("arst_dq_oe", int'(bus.sram_dq_oe), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_overrun", int'(bus.overrun), 0);
        @(negedge clock_50);
        reset_n = 1'b1;
        watch(20);
        chk("arst_no_done", ev_port.size(), 0);
        chk("arst_idle", busy_hi, 0);

        // Still fully functional after the abort
        sched.push_back('{0, 1, 1'b0, 16'h1234, 8'h00});
        watch(14);
        chk("post_ndone", ev_port.size(), 1);
        if (ev_port.size() >= 1) chk("post_latency", ev_cyc[0] - 1, 9);
        chk("post_a_rdata", int'(bus.a_rdata), 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
